eth_tx_frame_reader: RTL

Transmit-side reader for the Ethernet frame buffer. It fetches a frame from the 64-bit wide port of the dual-port buffer (1-cycle read latency) and narrows it into a byte stream with a valid/ready handshake toward the TX MAC. It is the counterpart of the RX path, where bytes are widened into 64-bit words. A one-word prefetch sustains one byte per cycle under no back-pressure.

---
 rtl/eth_tx_frame_reader_pkg.sv | 13 +
 rtl/eth_tx_frame_reader_if.sv | 22 ++
 rtl/eth_tx_frame_reader_narrow.sv | 76 +++++++
 rtl/eth_tx_frame_reader.sv | 122 ++++++++++++
 4 files changed

// File: rtl/eth_tx_frame_reader_pkg.sv
// Shared types and constants for the Ethernet TX frame reader.
package eth_tx_pkg;

    localparam int BYTES_PER_WORD = 8;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        RUN,
        FINISH
    } tx_state_t;

endpackage

// File: rtl/eth_tx_frame_reader_if.sv
// Buffer read port plus byte stream toward the TX MAC, seen from the reader (master).
interface eth_tx_frame_reader_if #(
    parameter int ADDR_W = 11
);
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [63:0]       mem_rdata;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_last;
    logic              tx_ready;

    modport master (
        output mem_en, mem_addr, tx_data, tx_valid, tx_last,
        input  mem_rdata, tx_ready
    );

    modport slave (
        input  mem_en, mem_addr, tx_data, tx_valid, tx_last,
        output mem_rdata, tx_ready
    );
endinterface

// File: rtl/eth_tx_frame_reader_narrow.sv
// Narrows 64-bit words into a little-endian byte stream; a one-word prefetch
// register keeps the stream gapless across word boundaries.
module eth_tx_word_narrow
    import eth_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic [63:0] i_word,
    input  logic [3:0]  i_nbytes,
    input  logic        i_last,
    input  logic        i_ready,
    output logic [7:0]  o_data,
    output logic        o_valid,
    output logic        o_last,
    output logic        o_pf_free
);
    logic [63:0] r_shift;
    logic [3:0]  r_cnt;
    logic        r_last;
    logic [63:0] r_pf_data;
    logic [3:0]  r_pf_cnt;
    logic        r_pf_last;
    logic        r_pf_valid;
    logic        w_fire;
    logic        w_shift_free;

    assign o_valid      = (r_cnt != 4'd0);
    assign o_data       = r_shift[7:0];
    assign o_last       = r_last && (r_cnt == 4'd1);
    assign w_fire       = o_valid && i_ready;
    assign w_shift_free = (r_cnt == 4'd0) || (w_fire && (r_cnt == 4'd1));
    assign o_pf_free    = !r_pf_valid || w_shift_free;

    // The prefetch only fills while the shift register is busy, so whenever it
    // holds a word the shift register is non-empty and takes it the moment it frees.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift    <= '0;
            r_cnt      <= '0;
            r_last     <= 1'b0;
            r_pf_data  <= '0;
            r_pf_cnt   <= '0;
            r_pf_last  <= 1'b0;
            r_pf_valid <= 1'b0;
        end else begin
            if (w_shift_free) begin
                if (r_pf_valid) begin
                    r_shift    <= r_pf_data;
                    r_cnt      <= r_pf_cnt;
                    r_last     <= r_pf_last;
                    r_pf_valid <= i_load;
                end else if (i_load) begin
                    r_shift <= i_word;
                    r_cnt   <= i_nbytes;
                    r_last  <= i_last;
                end else begin
                    r_cnt  <= '0;
                    r_last <= 1'b0;
                end
            end else if (w_fire) begin
                r_shift <= {8'h00, r_shift[63:8]};
                r_cnt   <= r_cnt - 4'd1;
            end

            if (i_load && (r_pf_valid || !w_shift_free)) begin
                r_pf_data <= i_word;
                r_pf_cnt  <= i_nbytes;
                r_pf_last <= i_last;
            end
            if (i_load && !w_shift_free) begin
                r_pf_valid <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/eth_tx_frame_reader.sv
// TX frame reader: fetches a frame from the 64-bit buffer port and streams it
// byte by byte to the MAC; FSM, address and length counters live here.
module eth_tx_frame_reader
    import eth_tx_pkg::*;
#(
    parameter int ADDR_W = 11,
    parameter int LEN_W  = 11
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [LEN_W-1:0]  i_len,
    output logic              o_busy,
    output logic              o_done,
    eth_tx_frame_reader_if.master bus
);
    tx_state_t         r_state;
    logic              r_busy;
    logic              r_done;
    logic              r_mem_en;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_rd_pend;
    logic [LEN_W:0]    r_words_left;
    logic [LEN_W-1:0]  r_bytes_left;

    logic [LEN_W:0]    w_len_ext;
    logic              w_load_last;
    logic [3:0]        w_load_nbytes;
    logic              w_pf_free;
    logic              w_issue;
    logic              w_last_xfer;

    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign bus.mem_en   = r_mem_en;
    assign bus.mem_addr = r_mem_addr;

    // Remaining-byte count decides how much of each arriving word is real data.
    always_comb begin
        w_len_ext     = {1'b0, i_len} + (LEN_W+1)'(BYTES_PER_WORD - 1);
        w_load_last   = (r_bytes_left <= LEN_W'(BYTES_PER_WORD));
        w_load_nbytes = w_load_last ? r_bytes_left[3:0] : 4'(BYTES_PER_WORD);
        w_issue       = (r_state == RUN) && (r_words_left != '0) &&
                        !r_mem_en && !r_rd_pend && w_pf_free;
        w_last_xfer   = bus.tx_valid && bus.tx_ready && bus.tx_last;
    end

    eth_tx_word_narrow u_narrow (
        .clk       (clk),
        .rst       (rst),
        .i_load    (r_rd_pend),
        .i_word    (bus.mem_rdata),
        .i_nbytes  (w_load_nbytes),
        .i_last    (w_load_last),
        .i_ready   (bus.tx_ready),
        .o_data    (bus.tx_data),
        .o_valid   (bus.tx_valid),
        .o_last    (bus.tx_last),
        .o_pf_free (w_pf_free)
    );

    // The first read is issued on the start edge itself so data lands two edges later.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_mem_en     <= 1'b0;
            r_mem_addr   <= '0;
            r_rd_pend    <= 1'b0;
            r_words_left <= '0;
            r_bytes_left <= '0;
        end else begin
            r_rd_pend <= r_mem_en;
            r_done    <= 1'b0;
            if (r_rd_pend) begin
                r_bytes_left <= r_bytes_left - LEN_W'(w_load_nbytes);
            end
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        if (i_len != '0) begin
                            r_state      <= FETCH;
                            r_busy       <= 1'b1;
                            r_mem_en     <= 1'b1;
                            r_mem_addr   <= i_base_addr;
                            r_words_left <= (w_len_ext >> 3) - (LEN_W+1)'(1);
                            r_bytes_left <= i_len;
                        end else begin
                            r_state <= FINISH;
                            r_done  <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    r_mem_en <= 1'b0;
                    r_state  <= RUN;
                end
                RUN: begin
                    r_mem_en <= w_issue;
                    if (w_issue) begin
                        r_mem_addr   <= r_mem_addr + ADDR_W'(1);
                        r_words_left <= r_words_left - (LEN_W+1)'(1);
                    end
                    if (w_last_xfer) begin
                        r_state <= FINISH;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                FINISH: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule
